// File: rtl/booth_mul_arbiter_pkg.sv
// booth_mul_arbiter_pkg: shared types, default widths and index-width helper for the Booth multiplier arbiter
package booth_arb_pkg;
    localparam int W = 16;
    localparam int PW = 32;
    typedef enum logic [2:0] {IDLE, START, LDM, LDQ, WAIT, RESP, CLR} state_e;
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if: requester, response and multiplier-core signals of the arbiter
interface booth_mul_arbiter_if #(parameter int NREQ = 4, parameter int W = booth_arb_pkg::W);
    localparam int IW = booth_arb_pkg::ptr_w(NREQ);
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic rsp_valid;
    logic rsp_ready;
    logic [IW-1:0] rsp_id;
    logic [2*W-1:0] rsp_product;
    logic rsp_err;
    logic mul_start;
    logic [W-1:0] mul_data;
    logic mul_clr;
    logic mul_done;
    logic [2*W-1:0] mul_result;
    modport slave (
        input req_valid, req_a, req_b, rsp_ready, mul_done, mul_result,
        output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_start, mul_data, mul_clr
    );
    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_done, mul_result,
        input req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_start, mul_data, mul_clr
    );
endinterface

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from ptr+1 with wrap
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW = booth_arb_pkg::ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        // walk farthest-first so the nearest requester after ptr wins
        for (int i = NREQ; i >= 1; i--) begin
            logic [IW-1:0] j;
            j = IW'((int'(ptr_i) + i) % NREQ);
            if (req_i[j]) begin
                gnt_o = NREQ'(1) << j;
                idx_o = j;
            end
        end
    end
endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin front end sequencing a shared radix-4 Booth multiplier core.
// Define BOOTH_ARB_WATCHDOG_EN to build the core-wait watchdog that reports rsp_err.
module booth_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int W = booth_arb_pkg::W,
    parameter int TIMEOUT = 64
) (
    input logic clk,
    input logic rst_n,
    booth_mul_arbiter_if.slave bus
);
    import booth_arb_pkg::*;
    localparam int IW = ptr_w(NREQ);
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_cfg_err
        $error("booth_mul_arbiter: unsupported NREQ or TIMEOUT");
    end
    state_e state_q;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0] gnt_idx, ptr_q, id_q;
    logic [W-1:0] a_q, b_q, mul_data_q;
    logic [2*W-1:0] prod_q;
    logic mul_start_q;
    logic [W-1:0] a_arr [NREQ];
    logic [W-1:0] b_arr [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = bus.req_a[g*W +: W];
        assign b_arr[g] = bus.req_b[g*W +: W];
    end
    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req_i(bus.req_valid),
        .ptr_i(ptr_q),
        .gnt_o(gnt),
        .idx_o(gnt_idx)
    );
`ifdef BOOTH_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] wd_q;
    logic err_q;
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= IW'(NREQ-1);
            id_q <= '0;
            a_q <= '0;
            b_q <= '0;
            prod_q <= '0;
            mul_start_q <= 1'b0;
            mul_data_q <= '0;
`ifdef BOOTH_ARB_WATCHDOG_EN
            wd_q <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            mul_start_q <= 1'b0;
            mul_data_q <= '0;
            case (state_q)
                IDLE: if (|gnt) begin
                    a_q <= a_arr[gnt_idx];
                    b_q <= b_arr[gnt_idx];
                    id_q <= gnt_idx;
                    ptr_q <= gnt_idx;
                    mul_start_q <= 1'b1;
                    state_q <= START;
                end
                START: begin
                    mul_data_q <= a_q;
                    state_q <= LDM;
                end
                LDM: begin
                    mul_data_q <= b_q;
                    state_q <= LDQ;
                end
                LDQ: begin
`ifdef BOOTH_ARB_WATCHDOG_EN
                    wd_q <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
`ifdef BOOTH_ARB_WATCHDOG_EN
                    wd_q <= wd_q + CW'(1);
                    if (wd_q == CW'(TIMEOUT-1)) begin
                        prod_q <= '0;
                        err_q <= 1'b1;
                        state_q <= RESP;
                    end
`endif
                    // a done in the expiry cycle still delivers the real product
                    if (bus.mul_done) begin
                        prod_q <= bus.mul_result;
`ifdef BOOTH_ARB_WATCHDOG_EN
                        err_q <= 1'b0;
`endif
                        state_q <= RESP;
                    end
                end
                RESP: if (bus.rsp_ready) state_q <= CLR;
                CLR: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.req_ready = (rst_n && state_q == IDLE) ? gnt : '0;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_id = id_q;
    assign bus.rsp_product = prod_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_data = mul_data_q;
    assign bus.mul_clr = !rst_n || state_q == CLR;
endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin front end that shares one radix-4 Booth multiplier core (16x16 signed → 32-bit) among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and sequences the core's start/load protocol: start, then multiplicand on `mul_data`, then multiplier on `mul_data`. It waits for `mul_done`, returns the tagged product on a single response channel, and clears the core for the next job.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 16, operand width; product is 2*W
- TIMEOUT, 64, core-wait watchdog limit in cycles (used only with the watchdog macro)
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  reset; synchronous and active-low (fixed)
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot accept; at most one bit high per cycle
- req_a  in  NREQ*W  multiplicands, requester i at [i*W +: W]
- req_b  in  NREQ*W  multipliers, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  clog2(NREQ)  index of the requester that owns the response
- rsp_product  out  2*W  signed product
- rsp_err  out  1  watchdog expiry flag; product is 0 when set
- mul_start  out  1  core start pulse
- mul_data  out  W  core shared operand bus
- mul_clr  out  1  returns the core to idle and clears its A/Q/M registers
- mul_done  in  1  core done level
- mul_result  in  2*W  core {A,Q}

## Operation
- FSM states: IDLE, START, LDM, LDQ, WAIT, RESP, CLR.
- **IDLE**
  - `req_ready` = the round-robin winner among `req_valid`. Search begins at `ptr+1` and wraps modulo NREQ.
  - On handshake, capture a/b/id into job registers, set `ptr` = winner, go to START.
  - With no valid requests, stay in IDLE; `ptr` is unchanged.
- **START**: `mul_start`=1 for one cycle, then go to LDM.
- **LDM**: `mul_data` = job_a for one cycle (core loads M), then go to LDQ.
- **LDQ**: `mul_data` = job_b for one cycle (core loads Q), then go to WAIT.
- **WAIT**: `mul_data`=0. On `mul_done`=1, register `mul_result` into `rsp_product` and go to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_id`, `rsp_product` and `rsp_err` hold stable until `rsp_ready`.
  - On `rsp_valid`&`rsp_ready`, go to CLR.
- **CLR**: `mul_clr`=1 for one cycle, then go to IDLE.
- `req_ready` is 0 in every state except IDLE. Exactly one job is in flight at a time.
- Requesters hold `req_valid`, a and b stable until accepted. Deasserting `req_valid` before accept is legal and drops the request.
- A requester may re-request immediately after acceptance. It is not re-granted while any other requester is valid (fairness).
- `mul_done` seen outside WAIT is ignored.

## Timing
- Reset (`rst_n`=0 at a clock edge)
  - FSM → IDLE; `ptr` → NREQ-1, so requester 0 has first priority.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `rsp_err`=0, `mul_start`=0, `mul_data`=0.
  - `mul_clr`=1 while `rst_n` is low.
- Reset mid-job aborts the job with no response. The core is cleared by `mul_clr` held during reset.
- Cycle numbering, with cycle 0 = accept cycle:
  - `mul_start` at cycle 1.
  - A on `mul_data` at cycle 2.
  - B on `mul_data` at cycle 3.
  - `rsp_valid` rises the cycle after the first `mul_done`=1 sampled in WAIT.
- Fixed arbiter overhead: 4 cycles before the core computes; response-to-next-accept is ≥2 cycles (CLR, then IDLE).
- Back-to-back throughput: one job per (core latency + 6) cycles with `rsp_ready` tied high.

## Configuration
- Macro: `BOOTH_ARB_WATCHDOG_EN`.
- **Defined**
  - A counter runs in WAIT. It is cleared on entry to WAIT and counts up each cycle without `mul_done`.
  - When it reaches TIMEOUT-1 without `mul_done`: `rsp_product`=0, `rsp_err`=1, go to RESP, then CLR as normal.
- **Undefined**: no counter is built, `rsp_err` is tied 0, and WAIT waits indefinitely.

## Structure
- Package `booth_arb_pkg`:
  - FSM state enum.
  - Default widths W=16 and PW=32.
  - Function for `ptr` width (clog2).
- Sub-module `rr_arbiter`, combinational:
  - Inputs: NREQ-bit request vector and `ptr`.
  - Outputs: one-hot grant and encoded index.
  - The registered `ptr` stays in the top level.

## Test plan
- **Single job**: req0 a=16'h0003, b=16'hFFFB (-5) → `mul_start` at cycle 1, A/B on `mul_data` at cycles 2/3; `rsp_id`=0, `rsp_product`=32'hFFFFFFF1 (-15), `mul_clr` pulse after the handshake.
- **All four valid after reset**: grants in order 0,1,2,3. req1 re-asserts during job 3 → next grant is 0 if req0 is valid, otherwise 1.
- **Backpressure**: `rsp_ready`=0 for 10 cycles → `rsp_valid` and all response fields stay constant; no `req_ready` and no `mul_clr` until the handshake.
- **Reset mid-job**: `rst_n` low during WAIT → next cycle: IDLE, `rsp_valid`=0, `mul_clr`=1, `ptr`=NREQ-1. After release, a new req2 job completes correctly.
- **Watchdog** (`BOOTH_ARB_WATCHDOG_EN`, TIMEOUT=64): `mul_done` held low → `rsp_valid` with `rsp_err`=1 and `rsp_product`=0 at WAIT-entry+64; without the macro, the FSM remains in WAIT.
- **Corner products**: a=16'h8000, b=16'h8000 → 32'h40000000; a=16'h7FFF, b=16'h8000 → 32'hC0008000.
